// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, opcode enumeration and the result record
// that is captured after each ALU operation.
package alu_pkg;

  localparam int unsigned ALU_OPCODE_W = 3;
  localparam int unsigned ALU_DATA_W   = 16;

  typedef enum logic [ALU_OPCODE_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic                  overflow;
    alu_op_e               opcode;
    logic [ALU_DATA_W-1:0] data;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo_mem.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one asynchronous read port.
module alu_result_fifo_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 20
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Storage is deliberately unreset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// First-word-fall-through buffer for ALU results with drop counting while full.
// Define ALU_RESULT_OVF_CNT_EN to add the ovf_count port and counter.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_overflow,
  input  logic [ALU_OPCODE_W-1:0]   in_opcode,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_overflow,
  output logic [ALU_OPCODE_W-1:0]   out_opcode,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_W-1:0]          drop_count
`ifdef ALU_RESULT_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0]          ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Same field layout as alu_result_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             overflow;
    alu_op_e          opcode;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop, drop;
  entry_t        wr_entry, rd_entry;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = in_valid && !full;
  assign drop  = in_valid && full;
  assign pop   = !empty && out_ready;

  assign wr_entry = '{overflow: in_overflow, opcode: alu_op_e'(in_opcode), data: in_data};

  alu_result_fifo_mem #(
    .DEPTH  (DEPTH),
    .ENTRY_W($bits(entry_t))
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wr_entry),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
    end
  end

`ifdef ALU_RESULT_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (push && in_overflow && ovf_count != '1) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end
`endif

  // Head fields are masked while empty so they read as zero.
  always_comb begin
    out_data     = '0;
    out_overflow = 1'b0;
    out_opcode   = '0;
    if (!empty) begin
      out_data     = rd_entry.data;
      out_overflow = rd_entry.overflow;
      out_opcode   = rd_entry.opcode;
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer against a queue-based model.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_overflow = 1'b0;
  logic [2:0]       in_opcode = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_overflow;
  logic [2:0]       out_opcode;
  logic             out_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] drop_count;
`ifdef ALU_RESULT_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_count;
`endif

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_overflow (in_overflow),
    .in_opcode   (in_opcode),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_overflow(out_overflow),
    .out_opcode  (out_opcode),
    .out_ready   (out_ready),
    .level       (level),
    .drop_count  (drop_count)
`ifdef ALU_RESULT_OVF_CNT_EN
    ,
    .ovf_count   (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue with saturating counters.
  alu_result_t q[$];
  int unsigned m_drop = 0;
  int unsigned m_ovf = 0;
  localparam int unsigned SAT = (1 << CNT_W) - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_drop = 0;
      m_ovf  = 0;
    end else begin
      automatic bit was_full = (q.size() == DEPTH);
      automatic bit do_pop   = (q.size() != 0) && out_ready;
      if (in_valid && was_full) begin
        if (m_drop < SAT) m_drop++;
      end
      if (do_pop) void'(q.pop_front());
      if (in_valid && !was_full) begin
        q.push_back('{overflow: in_overflow, opcode: alu_op_e'(in_opcode), data: in_data});
        if (in_overflow && m_ovf < SAT) m_ovf++;
      end
    end
  end

  always @(negedge clk) begin
    automatic alu_result_t h = (q.size() != 0) ? q[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    chk("level",     32'(level),     32'(q.size()));
    chk("out_data",  32'(out_data),  32'(h.data));
    chk("out_ovf",   32'(out_overflow), 32'(h.overflow));
    chk("out_op",    32'(out_opcode), 32'(h.opcode));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`ifdef ALU_RESULT_OVF_CNT_EN
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
`endif
  end

  // Drive inputs, then let one rising edge apply them; returns at edge+1.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ovf,
                      input logic [2:0] op, input logic rdy);
    in_valid = v; in_data = d; in_overflow = ovf; in_opcode = op; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step(1'b0, '0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // Basic push/pop with 1-cycle latency.
    step(1'b1, 16'h0018, 1'b0, 3'd0, 1'b0);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'h18);
    chk("basic_level", 32'(level), 32'd1);
    step(1'b0, '0, 1'b0, 3'd0, 1'b1);
    chk("basic_drain", 32'(level), 32'd0);

    // Fill past capacity; first four survive, two are dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 3'(i), 1'b0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_drop", 32'(drop_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", 32'(out_data), 32'(16'h0100 + i));
      step(1'b0, '0, 1'b0, 3'd0, 1'b1);
    end
    chk("fill_empty", 32'(out_valid), 32'd0);

    // Push and pop together while full: pop wins, push dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 3'd1, 1'b0);
    step(1'b1, 16'h02FF, 1'b0, 3'd1, 1'b1);
    chk("fullpp_level", 32'(level), 32'd3);
    chk("fullpp_drop", 32'(drop_count), 32'd3);
    chk("fullpp_head", 32'(out_data), 32'h0201);
    for (int i = 1; i < 4; i++) begin
      chk("fullpp_order", 32'(out_data), 32'(16'h0200 + i));
      step(1'b0, '0, 1'b0, 3'd0, 1'b1);
    end

    // Pointer wrap with steady-state push+pop.
    step(1'b1, 16'd1, 1'b0, 3'd2, 1'b1);
    for (int i = 2; i <= 10; i++) begin
      chk("wrap_level", 32'(level), 32'd1);
      chk("wrap_data", 32'(out_data), 32'(i - 1));
      step(1'b1, 16'(i), 1'b0, 3'd2, 1'b1);
    end
    chk("wrap_last", 32'(out_data), 32'd10);
    step(1'b0, '0, 1'b0, 3'd0, 1'b1);
    chk("wrap_empty", 32'(level), 32'd0);

    // Randomized traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      automatic int unsigned phase = (i / 200) % 3;
      automatic logic rdy = (phase == 0) ? ($urandom_range(0, 3) == 0)
                          : (phase == 1) ? ($urandom_range(0, 1) == 1)
                                         : ($urandom_range(0, 7) != 0);
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), 3'($urandom), rdy);
    end

`ifdef ALU_RESULT_OVF_CNT_EN
    do_reset();
    step(1'b1, 16'h1, 1'b1, 3'd0, 1'b0);
    step(1'b1, 16'h2, 1'b1, 3'd0, 1'b0);
    step(1'b1, 16'h3, 1'b0, 3'd0, 1'b0);
    step(1'b1, 16'h4, 1'b0, 3'd0, 1'b0);
    step(1'b1, 16'h5, 1'b1, 3'd0, 1'b0);
    chk("ovf_count_lit", 32'(ovf_count), 32'd2);
    chk("ovf_drop_lit", 32'(drop_count), 32'd1);
`endif

    // Asynchronous reset in the middle of a cycle with three entries held.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0300 + i), 1'b1, 3'd3, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_drop", 32'(drop_count), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
`ifdef ALU_RESULT_OVF_CNT_EN
    chk("arst_ovf", 32'(ovf_count), 32'd0);
`endif
    step(1'b0, '0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, '0, 1'b0, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
